// File: rtl/cpu_pkg.sv
// CPU-level defaults and register-index names shared by the datapath blocks.
package cpu_pkg;

  localparam int CPU_WIDTH = 8;
  localparam int CPU_NREGS = 4;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_C = 2'd2,
    REG_D = 2'd3
  } reg_idx_e;

endpackage

// File: rtl/regbank_rdport.sv
// One read port of the register bank: write-forwarding select feeding a registered operand.
module regbank_rdport
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int NREGS = CPU_NREGS,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [SELW-1:0]  sel,
  input  logic             we,
  input  logic [SELW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] regs [NREGS],
  output logic [WIDTH-1:0] dout,
  output logic             sel_bad
);

  // One extra bit so NREGS itself is representable when it is a power of two.
  localparam logic [SELW:0] NREGS_X = (SELW+1)'(NREGS);

  logic             sel_ok;
  logic [WIDTH-1:0] rd_p0;
  logic [WIDTH-1:0] dout_p1;

  assign sel_ok  = ({1'b0, sel} < NREGS_X);
  assign sel_bad = !sel_ok;

  // p0: same-cycle write wins over stored value; out-of-range reads as zero
  always_comb begin
    rd_p0 = '0;
    if (we && (waddr == sel) && sel_ok) begin
      rd_p0 = wdata;
    end else if (sel_ok) begin
      rd_p0 = regs[sel];
    end
  end

  // p1: operand register, holds between captures
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
    end else if (re) begin
      dout_p1 <= rd_p0;
    end
  end

  assign dout = dout_p1;

endmodule

// File: rtl/regbank_rd2.sv
// Register bank with one write port and two registered, write-forwarding read ports.
module regbank_rd2
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int NREGS = CPU_NREGS,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SELW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [SELW-1:0]  sel_a,
  input  logic [SELW-1:0]  sel_b,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic             out_valid,
  output logic             sel_err
);

  localparam logic [SELW:0] NREGS_X = (SELW+1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic             waddr_ok;
  logic             a_bad;
  logic             b_bad;
  logic             vld_p1;
  logic             sel_err_p1;

  assign waddr_ok = ({1'b0, waddr} < NREGS_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  regbank_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .SELW(SELW)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .re      (re),
    .sel     (sel_a),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .regs    (regs),
    .dout    (Aout),
    .sel_bad (a_bad)
  );

  regbank_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .SELW(SELW)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .re      (re),
    .sel     (sel_b),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .regs    (regs),
    .dout    (Bout),
    .sel_bad (b_bad)
  );

  // p1: capture pulse and sticky bad-index flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      sel_err_p1 <= 1'b0;
    end else begin
      vld_p1 <= re;
      if ((we && !waddr_ok) || (re && (a_bad || b_bad))) begin
        sel_err_p1 <= 1'b1;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sel_err   = sel_err_p1;

endmodule

// File: tb/tb_regbank_rd2.sv
// Bench for regbank_rd2 with a non-power-of-two bank (5 registers, 3-bit selects).
module tb_regbank_rd2;

  localparam int W = 8;
  localparam int N = 5;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         we = 1'b0;
  logic [S-1:0] waddr = '0;
  logic [W-1:0] wdata = '0;
  logic         re = 1'b0;
  logic [S-1:0] sel_a = '0;
  logic [S-1:0] sel_b = '0;
  logic [W-1:0] Aout;
  logic [W-1:0] Bout;
  logic         out_valid;
  logic         sel_err;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents and expected outputs after the last edge.
  logic [W-1:0] mreg [N];
  logic [W-1:0] ea = '0;
  logic [W-1:0] eb = '0;
  logic         ev = 1'b0;
  logic         ee = 1'b0;

  regbank_rd2 #(.WIDTH(W), .NREGS(N), .SELW(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (re),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .Aout      (Aout),
    .Bout      (Bout),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_rd(input int s, input logic w, input int wa, input int wd);
    if (s >= N) return '0;
    if (w && wa == s) return W'(wd);
    return mreg[s];
  endfunction

  // Drive one cycle of inputs, advance the reference, and land 1 time unit after the edge.
  task automatic step(input logic w, input int wa, input int wd,
                      input logic r, input int sa, input int sb, input logic rs);
    rst = rs; we = w; waddr = S'(wa); wdata = W'(wd);
    re = r; sel_a = S'(sa); sel_b = S'(sb);
    if (rs) begin
      for (int i = 0; i < N; i++) mreg[i] = '0;
      ea = '0; eb = '0; ev = 1'b0; ee = 1'b0;
    end else begin
      ev = r;
      if (r) begin
        ea = model_rd(sa, w, wa, wd);
        eb = model_rd(sb, w, wa, wd);
        if (sa >= N || sb >= N) ee = 1'b1;
      end
      if (w) begin
        if (wa < N) mreg[wa] = W'(wd);
        else ee = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    checks++; if (Aout !== 8'd0) begin errors++; $display("FAIL reset_aout got %0d want 0", Aout); end
    checks++; if (Bout !== 8'd0) begin errors++; $display("FAIL reset_bout got %0d want 0", Bout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", out_valid); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", sel_err); end
  endtask

  task automatic test_write_read();
    step(1'b1, 0, 122, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1, 4,   1'b0, 0, 0, 1'b0);
    step(1'b1, 2, 181, 1'b0, 0, 0, 1'b0);
    step(1'b1, 3, 13,  1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0,   1'b1, 0, 3, 1'b0);
    checks++; if (Aout !== 8'd122) begin errors++; $display("FAIL rd_aout got %0d want 122", Aout); end
    checks++; if (Bout !== 8'd13) begin errors++; $display("FAIL rd_bout got %0d want 13", Bout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_vld got %b want 1", out_valid); end
  endtask

  task automatic test_forward();
    step(1'b1, 2, 47, 1'b1, 2, 1, 1'b0);
    checks++; if (Aout !== 8'd47) begin errors++; $display("FAIL fwd_aout got %0d want 47", Aout); end
    checks++; if (Bout !== 8'd4) begin errors++; $display("FAIL fwd_bout got %0d want 4", Bout); end
    step(1'b0, 0, 0, 1'b1, 2, 2, 1'b0);
    checks++; if (Aout !== 8'd47) begin errors++; $display("FAIL fwd_later got %0d want 47", Aout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_vld got %b want 1", out_valid); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 28, 1'b0, 0, 0, 1'b0);
      checks++; if (Aout !== 8'd47 || Bout !== 8'd47) begin
        errors++; $display("FAIL hold_data cyc %0d got %0d/%0d want 47/47", i, Aout, Bout);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_vld cyc %0d got %b want 0", i, out_valid); end
    end
    step(1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
    checks++; if (Aout !== 8'd28) begin errors++; $display("FAIL hold_rewrite got %0d want 28", Aout); end
  endtask

  task automatic test_same_sel();
    step(1'b1, 1, 193, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1, 1, 1'b0);
    checks++; if (Aout !== 8'd193 || Bout !== 8'd193) begin
      errors++; $display("FAIL same_sel got %0d/%0d want 193/193", Aout, Bout);
    end
  endtask

  task automatic test_sel_err();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL err_pre got %b want 0", sel_err); end
    step(1'b0, 0, 0, 1'b1, 6, 0, 1'b0);
    checks++; if (Aout !== 8'd0) begin errors++; $display("FAIL err_aout got %0d want 0", Aout); end
    checks++; if (Bout !== 8'd28) begin errors++; $display("FAIL err_bout got %0d want 28", Bout); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sel_err); end
    step(1'b1, 7, 99, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < N; i++) begin
      step(1'b0, 0, 0, 1'b1, i, i, 1'b0);
      checks++; if (Aout !== mreg[i]) begin
        errors++; $display("FAIL err_nowrite r%0d got %0d want %0d", i, Aout, mreg[i]);
      end
    end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", sel_err); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 0, 246, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1, 196, 1'b0, 0, 0, 1'b0);
    step(1'b1, 2, 77,  1'b1, 0, 1, 1'b0);
    checks++; if (Aout !== 8'd246 || Bout !== 8'd196) begin
      errors++; $display("FAIL mid_cap got %0d/%0d want 246/196", Aout, Bout);
    end
    step(1'b1, 3, 55, 1'b1, 0, 1, 1'b1);
    checks++; if (Aout !== 8'd0 || Bout !== 8'd0) begin
      errors++; $display("FAIL mid_rst_data got %0d/%0d want 0/0", Aout, Bout);
    end
    checks++; if (out_valid !== 1'b0 || sel_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctl got vld=%b err=%b want 0/0", out_valid, sel_err);
    end
    step(1'b0, 0, 0, 1'b1, 2, 3, 1'b0);
    checks++; if (Aout !== 8'd0 || Bout !== 8'd0) begin
      errors++; $display("FAIL mid_post_rd got %0d/%0d want 0/0", Aout, Bout);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 63) == 0));
      checks++; if (Aout !== ea || Bout !== eb || out_valid !== ev || sel_err !== ee) begin
        errors++;
        $display("FAIL rand_%0d got A=%0d B=%0d v=%b e=%b want A=%0d B=%0d v=%b e=%b",
                 n, Aout, Bout, out_valid, sel_err, ea, eb, ev, ee);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mreg[i] = '0;
    test_reset();
    test_write_read();
    test_forward();
    test_hold();
    test_same_sel();
    test_sel_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
